// File: rtl/led_blink_stretcher.sv
// Event-driven LED blink stretcher: queues event pulses and plays each as an ON blink followed by a forced-off GAP.
// Optional sticky overflow flag (ovf/ovf_clr ports) is enabled by defining BLINK_OVF_EN.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no blink running; starts one as soon as pending != 0
// S_ON   | led lit, counting ON_TICKS slow ticks
// S_GAP  | led dark, counting GAP_TICKS slow ticks before next blink
module led_blink_stretcher #(
  parameter int TICK_DIV  = 250000,
  parameter int ON_TICKS  = 40,
  parameter int GAP_TICKS = 40,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt,
`ifdef BLINK_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int PH_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              dec;
  logic              drop;

  // Free-running prescaler; tick is independent of the FSM.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ON;
          phase_d = '0;
          dec     = 1'b1;
        end
      end
      S_ON: begin
        if (tick) begin
          if (phase_q == ON_LAST) begin
            state_d = S_GAP;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (phase_q == GAP_LAST) begin
            state_d = S_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
    // Outputs decode the next state so the flops line up with state_q.
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  // A blink start on the same edge as an event absorbs it even at saturation.
  always_comb begin
    drop   = 1'b0;
    pend_d = pend_q;
    if (evt && !dec) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!evt && dec) begin
      pend_d = pend_q - 1'b1;
    end
  end

`ifdef BLINK_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_led_blink_stretcher.sv
// Directed bench for led_blink_stretcher with TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1, PEND_W=2.
// Covers the ovf/ovf_clr ports when BLINK_OVF_EN is defined.
module tb_led_blink_stretcher;

  logic       clk;
  logic       rst_n;
  logic       evt;
  logic       ovf_clr;
  logic       led;
  logic       busy;
  logic [1:0] pending;
`ifdef BLINK_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int   blinks;
  int   max_pend;
  int   low_run;
  int   min_gap;
  logic prev_led;

  led_blink_stretcher #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .GAP_TICKS(1),
    .PEND_W   (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .evt    (evt),
`ifdef BLINK_OVF_EN
    .ovf_clr(ovf_clr),
    .ovf    (ovf),
`endif
    .led    (led),
    .busy   (busy),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mon_reset();
    blinks   = 0;
    max_pend = 0;
    low_run  = 0;
    min_gap  = 1000;
    prev_led = led;
  endtask

  // One clock: sample 1 ns after the edge and update the blink monitor.
  task automatic step();
    @(posedge clk);
    #1;
    if (led && !prev_led) begin
      if (blinks > 0 && low_run < min_gap) min_gap = low_run;
      blinks++;
    end
    if (!led) low_run++;
    else low_run = 0;
    prev_led = led;
    if (int'(pending) > max_pend) max_pend = int'(pending);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  typedef struct {
    logic       evt;
    logic       led;
    logic       busy;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Single event from IDLE right after reset release; row k is checked after edge k+1.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1};
    for (int k = 1; k <= 6; k++)  tbl[k] = '{1'b0, 1'b1, 1'b1, 2'd0};
    for (int k = 7; k <= 10; k++) tbl[k] = '{1'b0, 1'b0, 1'b1, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0};

    rst_n   = 1'b0;
    evt     = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
`ifdef BLINK_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    rst_n = 1'b1;
    mon_reset();

    for (int i = 0; i < 13; i++) begin
      evt = tbl[i].evt;
      step();
      check($sformatf("single_led[%0d]", i), int'(led), int'(tbl[i].led));
      check($sformatf("single_busy[%0d]", i), int'(busy), int'(tbl[i].busy));
      check($sformatf("single_pend[%0d]", i), int'(pending), int'(tbl[i].pend));
    end
    evt = 1'b0;

    // Three back-to-back events.
    mon_reset();
    evt = 1'b1;
    repeat (3) step();
    evt = 1'b0;
    repeat (60) step();
    check("burst3_blinks", blinks, 3);
    check("burst3_peak", max_pend, 2);
    check("burst3_gap", min_gap, 5);
    check("burst3_pend_end", int'(pending), 0);
    check("burst3_busy_end", int'(busy), 0);
`ifdef BLINK_OVF_EN
    check("burst3_ovf", int'(ovf), 0);
`endif

    // Saturate without dropping, then hit the IDLE->ON edge with another event.
    for (int k = 0; k < 7; k++) begin
      evt = (k % 2 == 0);
      step();
    end
    evt = 1'b0;
    check("sat_build_pend", int'(pending), 3);
    wait_idle("sat_wait_idle");
    check("sat_idle_pend", int'(pending), 3);
    evt = 1'b1;
    step();
    evt = 1'b0;
    check("sat_accept_pend", int'(pending), 3);
    check("sat_accept_led", int'(led), 1);
`ifdef BLINK_OVF_EN
    check("sat_accept_ovf", int'(ovf), 0);
`endif

    // Reset in the middle of an ON phase with two events still queued.
    wait_idle("mid_wait_idle");
    step();
    check("mid_pre_pend", int'(pending), 2);
    check("mid_pre_led", int'(led), 1);
    #2;
    rst_n = 1'b0;
    evt   = 1'b1;
    #1;
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pend", int'(pending), 0);
    repeat (3) step();
    rst_n = 1'b1;
    evt   = 1'b0;
    mon_reset();
    repeat (30) step();
    check("post_rst_blinks", blinks, 0);
    check("post_rst_pend", int'(pending), 0);

    // Five events two cycles apart, plus clear/set interplay on ovf.
    mon_reset();
    for (int k = 0; k < 12; k++) begin
      evt     = (k % 2 == 0) && (k <= 10);
      ovf_clr = (k >= 9);
      step();
      if (k == 6) begin
        check("five_pend_k6", int'(pending), 3);
`ifdef BLINK_OVF_EN
        check("five_ovf_k6", int'(ovf), 0);
`endif
      end
      if (k == 8) begin
        check("five_pend_k8", int'(pending), 3);
`ifdef BLINK_OVF_EN
        check("five_ovf_drop", int'(ovf), 1);
`endif
      end
`ifdef BLINK_OVF_EN
      if (k == 9)  check("five_ovf_clr", int'(ovf), 0);
      if (k == 10) check("five_ovf_set_wins", int'(ovf), 1);
      if (k == 11) check("five_ovf_clr_alone", int'(ovf), 0);
`endif
    end
    evt     = 1'b0;
    ovf_clr = 1'b0;
    repeat (70) step();
    check("five_blinks", blinks, 4);
    check("five_peak", max_pend, 3);
    check("five_pend_end", int'(pending), 0);
    check("five_busy_end", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_blink_stretcher.md
LED_BLINK_STRETCHER -- requirements
Module: led_blink_stretcher

Interface
REQ-001 Parameter TICK_DIV, default 250000, clk cycles per slow tick (2.5 ms at 100 MHz); SHALL be >= 2.
REQ-002 Parameter ON_TICKS, default 40, slow ticks per blink-on phase; SHALL be >= 1.
REQ-003 Parameter GAP_TICKS, default 40, slow ticks of forced-off gap after each blink; SHALL be >= 1.
REQ-004 Parameter PEND_W, default 4, width of the pending-event counter (max 2^PEND_W-1 queued).
REQ-005 clk  input  1  single system clock, all state on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 evt  input  1  one-cycle event pulse (e.g. from the debounced button); each high cycle is one event.
REQ-008 led  output  1  visible blink output, high only in ON.
REQ-009 busy  output  1  high in ON or GAP.
REQ-010 pending  output  PEND_W  queued events not yet blinked.
REQ-011 ovf  output  1  sticky overflow flag (only with BLINK_OVF_EN).
REQ-012 ovf_clr  input  1  synchronous clear of ovf (only with BLINK_OVF_EN).

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 free-running from reset release, wrapping to 0; tick SHALL be high for exactly the cycle where count == TICK_DIV-1, independent of FSM state.
REQ-014 pending SHALL increment on each clk edge with evt=1, and decrement on the edge where the FSM leaves IDLE for ON.
REQ-015 Simultaneous increment and decrement SHALL leave pending unchanged, and the event SHALL count as accepted, including when pending is saturated.
REQ-016 evt at saturation (pending == 2^PEND_W-1) with no decrement that edge SHALL be dropped; pending SHALL stay at max, never wrap.
REQ-017 FSM states IDLE, ON, GAP; phase counter wide enough for max(ON_TICKS, GAP_TICKS).
REQ-018 IDLE: on an edge where pending != 0, SHALL go to ON with phase=0; evt to led-rise latency is 2 clk edges from IDLE with pending=0.
REQ-019 ON: phase SHALL increment on each tick; on the tick where phase == ON_TICKS-1, SHALL go to GAP with phase=0.
REQ-020 GAP: on the tick where phase == GAP_TICKS-1, SHALL go to IDLE; a queued event SHALL start its blink on the next edge.
REQ-021 ON duration SHALL be between (ON_TICKS-1)*TICK_DIV+1 and ON_TICKS*TICK_DIV clk cycles, depending on prescaler phase at entry; GAP likewise with GAP_TICKS.
REQ-022 led and busy SHALL be registered, glitch-free decodes of state.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, prescaler=0, phase=0, pending=0, led=0, busy=0, ovf=0.
REQ-024 Reset mid-blink SHALL abort the blink; queued events SHALL be discarded; evt during reset SHALL be ignored.

Configuration
REQ-025 Macro BLINK_OVF_EN defined: ovf and ovf_clr ports SHALL exist; ovf SHALL set on the edge an event is dropped per REQ-016 and clear on ovf_clr=1; simultaneous set and clear SHALL leave ovf=1.
REQ-026 BLINK_OVF_EN undefined: ovf and ovf_clr SHALL be absent; dropped events SHALL be silently discarded; all other behaviour identical.

Verification (TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1, PEND_W=2)
REQ-027 Single evt in IDLE -> pending=1 one edge later, led high 2 edges after evt for 5..8 cycles, busy low again within 12 cycles, pending=0.
REQ-028 evt high 3 consecutive cycles from IDLE -> pending peaks at 2, exactly 3 blinks each separated by >= 1 gap tick, ovf=0.
REQ-029 5 evt spaced 2 cycles from IDLE -> pending saturates at 3, ovf=1 after 5th evt, exactly 4 blinks total.
REQ-030 Saturated pending, evt on the IDLE->ON edge -> pending stays 3, ovf stays 0.
REQ-031 rst_n low mid-ON with pending=2 -> led=0 without a clk edge, after release no blink, pending=0.
REQ-032 ovf_clr=1 same cycle as dropped evt -> ovf=1; ovf_clr alone next cycle -> ovf=0; rebuild without BLINK_OVF_EN -> REQ-029 gives 4 blinks, no ovf port.
